// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MD_WAIT = 2'd2
    } ctrl_state_e;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic             is_load,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             rs_used,
        input logic             rt_used
    );
        return is_load && (rd != ZERO_REG) &&
               ((rs_used && (rs == rd)) || (rt_used && (rt == rd)));
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter bounding how long the pipeline may wait for the multiplier/divider.
module md_watchdog #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic clock,
    input  logic clr_n,
    input  logic i_clr,
    input  logic i_ena,
    output logic o_tc
);

    localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(MD_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_cnt;

    // Count up while enabled, parking at terminal count.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ena && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: drives enables and clears of the five pipeline registers
// for load-use bubbles, redirect flushes and mult/div freezes.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_rs_used,
    input  logic             d_rt_used,
    input  logic             x_is_load,
    input  logic [REG_W-1:0] x_rd,
    input  logic             x_redirect,
    input  logic             x_md_start,
    input  logic             md_ready,
    output logic             pc_ena,
    output logic             fd_ena,
    output logic             dx_ena,
    output logic             xm_ena,
    output logic             mw_ena,
    output logic             fd_clr,
    output logic             dx_clr,
    output logic             md_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic             r_fd_clr;
    logic             r_dx_clr;
    logic             w_fd_clr_nxt;
    logic             w_dx_clr_nxt;
    logic             r_md_timeout;
    logic             w_set_timeout;
    logic [CNT_W-1:0] r_stall;
    logic             w_lu;
    logic             w_wd_tc;

    assign w_lu = load_use_hazard(x_is_load, x_rd, d_rs, d_rt, d_rs_used, d_rt_used);

    md_watchdog #(
        .MD_TIMEOUT(MD_TIMEOUT)
    ) u_md_watchdog (
        .clock (clock),
        .clr_n (clr_n),
        .i_clr (r_state != ST_MD_WAIT),
        .i_ena (r_state == ST_MD_WAIT),
        .o_tc  (w_wd_tc)
    );

    // Next-state, enables, start pulse and next values of the registered clears.
    always_comb begin
        w_next_state  = r_state;
        pc_ena        = 1'b1;
        fd_ena        = 1'b1;
        dx_ena        = 1'b1;
        xm_ena        = 1'b1;
        mw_ena        = 1'b1;
        md_go         = 1'b0;
        w_fd_clr_nxt  = 1'b0;
        w_dx_clr_nxt  = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (x_redirect) begin
                    w_next_state = ST_FLUSH;
                    w_fd_clr_nxt = 1'b1;
                    w_dx_clr_nxt = 1'b1;
                end else if (x_md_start) begin
                    md_go        = 1'b1;
                    pc_ena       = 1'b0;
                    fd_ena       = 1'b0;
                    dx_ena       = 1'b0;
                    xm_ena       = 1'b0;
                    w_next_state = ST_MD_WAIT;
                end else if (w_lu) begin
                    // D/X captures the stalled instruction and is cleared on the next edge.
                    pc_ena       = 1'b0;
                    fd_ena       = 1'b0;
                    w_dx_clr_nxt = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                pc_ena       = 1'b0;
                w_next_state = ST_RUN;
            end
            ST_MD_WAIT: begin
                if (md_ready) begin
                    w_next_state = ST_RUN;
                end else if (w_wd_tc) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = ST_RUN;
                end else begin
                    pc_ena = 1'b0;
                    fd_ena = 1'b0;
                    dx_ena = 1'b0;
                    xm_ena = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // State, clear flops, sticky timeout and saturating stall counter.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_RUN;
            r_fd_clr     <= 1'b0;
            r_dx_clr     <= 1'b0;
            r_md_timeout <= 1'b0;
            r_stall      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_fd_clr     <= w_fd_clr_nxt;
            r_dx_clr     <= w_dx_clr_nxt;
            r_md_timeout <= r_md_timeout | w_set_timeout;
            if (!pc_ena && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + STALL_ONE;
            end else begin
                r_stall <= r_stall;
            end
        end
    end

    assign fd_clr       = r_fd_clr;
    assign dx_clr       = r_dx_clr;
    assign md_timeout   = r_md_timeout;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// against a behavioural model; a second instance with a 4-bit counter shows saturation.
module tb_pipe_hazard_ctrl;

    localparam int TO = 40;

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    logic [4:0] d_rs = 5'd0, d_rt = 5'd0, x_rd = 5'd0;
    logic       d_rs_used = 1'b0, d_rt_used = 1'b0, x_is_load = 1'b0;
    logic       x_redirect = 1'b0, x_md_start = 1'b0, md_ready = 1'b0;

    logic        a_pc, a_fd, a_dx, a_xm, a_mw, a_fdc, a_dxc, a_go, a_tmo;
    logic [15:0] a_stall;
    logic        b_pc, b_fd, b_dx, b_xm, b_mw, b_fdc, b_dxc, b_go, b_tmo;
    logic [3:0]  b_stall;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(16)) u_dut (
        .clock(clock), .clr_n(clr_n), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .x_is_load(x_is_load),
        .x_rd(x_rd), .x_redirect(x_redirect), .x_md_start(x_md_start),
        .md_ready(md_ready), .pc_ena(a_pc), .fd_ena(a_fd), .dx_ena(a_dx),
        .xm_ena(a_xm), .mw_ena(a_mw), .fd_clr(a_fdc), .dx_clr(a_dxc),
        .md_go(a_go), .md_timeout(a_tmo), .stall_cycles(a_stall));

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(4)) u_dut4 (
        .clock(clock), .clr_n(clr_n), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .x_is_load(x_is_load),
        .x_rd(x_rd), .x_redirect(x_redirect), .x_md_start(x_md_start),
        .md_ready(md_ready), .pc_ena(b_pc), .fd_ena(b_fd), .dx_ena(b_dx),
        .xm_ena(b_xm), .mw_ena(b_mw), .fd_clr(b_fdc), .dx_clr(b_dxc),
        .md_go(b_go), .md_timeout(b_tmo), .stall_cycles(b_stall));

    typedef struct {
        logic [4:0]  ena;
        logic [2:0]  ctl;    // {md_go, fd_clr, dx_clr}
        logic        tmo;
        logic [15:0] stall;
        logic [3:0]  stall4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: pending flush, mult/div wait with elapsed count, stall totals.
    bit m_flush, m_md, m_fdc, m_dxc, m_tmo;
    int m_elapsed, m_stall, m_stall4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input bit rsu,
                        input bit rtu, input bit rdr, input bit mds, input bit mdr);
        exp_t e;
        bit   lu, pc, fd, dx, xm, mw, go;
        bit   n_flush, n_md, n_fdc, n_dxc;
        @(negedge clock);
        clr_n = !rst; x_is_load = ld; x_rd = rd; d_rs = rs; d_rt = rt;
        d_rs_used = rsu; d_rt_used = rtu; x_redirect = rdr; x_md_start = mds; md_ready = mdr;
        if (rst) begin
            m_flush = 0; m_md = 0; m_fdc = 0; m_dxc = 0; m_tmo = 0;
            m_elapsed = 0; m_stall = 0; m_stall4 = 0;
        end
        e.tmo = m_tmo; e.stall = 16'(m_stall); e.stall4 = 4'(m_stall4);
        lu = ld && (rd != 5'd0) && ((rsu && rs == rd) || (rtu && rt == rd));
        {pc, fd, dx, xm, mw} = 5'b11111;
        go = 0; n_flush = 0; n_md = 0; n_fdc = 0; n_dxc = 0;
        if (m_flush) begin
            pc = 0;
        end else if (m_md) begin
            if (mdr) begin
                n_md = 0;
            end else if (m_elapsed == TO - 1) begin
                if (!rst) m_tmo = 1;
            end else begin
                {pc, fd, dx, xm} = 4'b0000;
                n_md = 1;
            end
        end else if (rdr) begin
            n_flush = 1; n_fdc = 1; n_dxc = 1;
        end else if (mds) begin
            go = 1; {pc, fd, dx, xm} = 4'b0000; n_md = 1;
        end else if (lu) begin
            pc = 0; fd = 0; n_dxc = 1;
        end
        e.ena = {pc, fd, dx, xm, mw};
        e.ctl = {go, m_fdc, m_dxc};
        sb_q.push_back(e);
        if (!rst) begin
            m_elapsed = (m_md && n_md) ? m_elapsed + 1 : 0;
            m_flush = n_flush; m_md = n_md; m_fdc = n_fdc; m_dxc = n_dxc;
            if (!pc) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the controller presents a result every cycle; compare it mid-low-phase.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("enables", {27'd0, a_pc, a_fd, a_dx, a_xm, a_mw}, {27'd0, e.ena});
                chk("go_clears", {29'd0, a_go, a_fdc, a_dxc}, {29'd0, e.ctl});
                chk("md_timeout", {31'd0, a_tmo}, {31'd0, e.tmo});
                chk("stall_cycles", {16'd0, a_stall}, {16'd0, e.stall});
                chk("enables_w4", {24'd0, b_pc, b_fd, b_dx, b_xm, b_mw, b_go, b_fdc, b_dxc},
                    {24'd0, e.ena, e.ctl});
                chk("stall_cycles_w4", {28'd0, b_stall}, {28'd0, e.stall4});
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs, then the two non-hazard variants, then via rt
        step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0);
        step(0, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0, 0, 0);
        idle(1);
        // redirect alone, then redirect with a load-use present
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0);
        idle(2);
        // mult/div with result 33 cycles after start; stray md_ready outside the wait
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        idle(32);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        idle(2);
        // watchdog expiry, sticky timeout
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        idle(45);
        // reset in MD_WAIT cycle 10
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        idle(9);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        idle(3);
        // random traffic on a small register range so hazards are frequent
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        // long wait that times out, then more load-use stalls after the timeout
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        idle(42);
        for (int i = 0; i < 20; i++) step(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 0);
        idle(2);
        @(negedge clock);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
